// File: rtl/vex_bus_pkg.sv
// Shared types and defaults for the VexRiscv iBus/dBus arbiter.
package vex_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic OWNER_IBUS = 1'b0;
    localparam logic OWNER_DBUS = 1'b1;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/vex_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the master
// that did not win last time.
module vex_rr_arb2
    import vex_bus_pkg::*;
(
    input  logic i_req_ibus,
    input  logic i_req_dbus,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant
);

    assign o_grant_valid = i_req_ibus || i_req_dbus;
    assign o_grant = (i_req_dbus && (!i_req_ibus || (i_last_grant == OWNER_IBUS)))
                     ? OWNER_DBUS : OWNER_IBUS;

endmodule

// File: rtl/vex_bus_arbiter.sv
// Shares one single-port memory bus between VexRiscv iBus and dBus, one
// outstanding transaction at a time. Define ARB_TIMEOUT_EN for the response watchdog.
module vex_bus_arbiter
    import vex_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iBus_cmd_valid,
    output logic                iBus_cmd_ready,
    input  logic [ADDR_W-1:0]   iBus_cmd_payload_address,
    output logic                iBus_rsp_valid,
    output logic [DATA_W-1:0]   iBus_rsp_payload_data,
    output logic                iBus_rsp_payload_error,
    input  logic                dBus_cmd_valid,
    output logic                dBus_cmd_ready,
    input  logic                dBus_cmd_payload_wr,
    input  logic [ADDR_W-1:0]   dBus_cmd_payload_address,
    input  logic [DATA_W-1:0]   dBus_cmd_payload_data,
    input  logic [DATA_W/8-1:0] dBus_cmd_payload_mask,
    output logic                dBus_rsp_valid,
    output logic [DATA_W-1:0]   dBus_rsp_payload_data,
    output logic                dBus_rsp_payload_error,
    output logic                mem_cmd_valid,
    input  logic                mem_cmd_ready,
    output logic                mem_cmd_wr,
    output logic [ADDR_W-1:0]   mem_cmd_address,
    output logic [DATA_W-1:0]   mem_cmd_data,
    output logic [DATA_W/8-1:0] mem_cmd_mask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_error,
    output logic                mem_abort
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    state_t              r_state;
    logic                r_owner;
    logic                r_last_grant;
    logic                r_cmd_valid;
    logic                r_cmd_wr;
    logic [ADDR_W-1:0]   r_cmd_address;
    logic [DATA_W-1:0]   r_cmd_data;
    logic [MASK_W-1:0]   r_cmd_mask;

    logic                w_gnt_valid;
    logic                w_gnt;
    logic                w_idle;
    logic                w_in_rsp;
    logic                w_fwd;
    logic                w_timeout;
    logic                w_rsp_valid;
    logic                w_rsp_error;
    logic [DATA_W-1:0]   w_rsp_data;

    vex_rr_arb2 u_arb (
        .i_req_ibus    (iBus_cmd_valid),
        .i_req_dbus    (dBus_cmd_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_gnt_valid),
        .o_grant       (w_gnt)
    );

    // Ready is combinational, so it must also be forced low while reset is held.
    assign w_idle   = reset && (r_state == IDLE);
    assign w_in_rsp = (r_state == RSP);
    assign w_fwd    = w_in_rsp && mem_rsp_valid;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_rsp_cnt;

    assign w_timeout = w_in_rsp && !mem_rsp_valid && (r_rsp_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_cnt <= '0;
        end else if (r_state == CMD) begin
            r_rsp_cnt <= '0;
        end else if (w_in_rsp && !mem_rsp_valid) begin
            r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] w_unused_cnt;

    assign w_unused_cnt = CNT_W'(TIMEOUT);
    assign w_timeout    = 1'b0;
`endif

    assign mem_abort = w_timeout;

    assign iBus_cmd_ready = w_idle && w_gnt_valid && (w_gnt == OWNER_IBUS);
    assign dBus_cmd_ready = w_idle && w_gnt_valid && (w_gnt == OWNER_DBUS);

    assign mem_cmd_valid   = r_cmd_valid;
    assign mem_cmd_wr      = r_cmd_wr;
    assign mem_cmd_address = r_cmd_address;
    assign mem_cmd_data    = r_cmd_data;
    assign mem_cmd_mask    = r_cmd_mask;

    // A real response in the watchdog cycle wins over the synthesized error.
    assign w_rsp_valid = w_fwd || w_timeout;
    assign w_rsp_data  = w_fwd ? mem_rsp_data : '0;
    assign w_rsp_error = w_fwd ? mem_rsp_error : w_timeout;

    assign iBus_rsp_valid         = w_rsp_valid && (r_owner == OWNER_IBUS);
    assign iBus_rsp_payload_data  = (r_owner == OWNER_IBUS) ? w_rsp_data : '0;
    assign iBus_rsp_payload_error = w_rsp_error && (r_owner == OWNER_IBUS);
    assign dBus_rsp_valid         = w_rsp_valid && (r_owner == OWNER_DBUS);
    assign dBus_rsp_payload_data  = (r_owner == OWNER_DBUS) ? w_rsp_data : '0;
    assign dBus_rsp_payload_error = w_rsp_error && (r_owner == OWNER_DBUS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_owner       <= OWNER_IBUS;
            r_last_grant  <= OWNER_IBUS;
            r_cmd_valid   <= 1'b0;
            r_cmd_wr      <= 1'b0;
            r_cmd_address <= '0;
            r_cmd_data    <= '0;
            r_cmd_mask    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner      <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_cmd_valid  <= 1'b1;
                        r_state      <= CMD;
                        if (w_gnt == OWNER_DBUS) begin
                            r_cmd_wr      <= dBus_cmd_payload_wr;
                            r_cmd_address <= dBus_cmd_payload_address;
                            r_cmd_data    <= dBus_cmd_payload_data;
                            r_cmd_mask    <= dBus_cmd_payload_mask;
                        end else begin
                            r_cmd_wr      <= 1'b0;
                            r_cmd_address <= iBus_cmd_payload_address;
                            r_cmd_data    <= '0;
                            r_cmd_mask    <= '1;
                        end
                    end
                end
                CMD: begin
                    if (mem_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= r_cmd_wr ? IDLE : RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid || w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vex_bus_arbiter.md
# vex_bus_arbiter

Shares one single-port memory bus between the VexRiscv instruction bus (iBus) and data bus (dBus). Accepts single-beat commands from both masters, grants one at a time by round-robin, and drives a registered command onto the shared memory port. Routes the read response back to the owning master. Sits between the core and the on-chip RAM/peripheral fabric in `top`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (mask width = `DATA_W/8`)
- `TIMEOUT`, 255, response watchdog limit in cycles (used only with `ARB_TIMEOUT_EN`)

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `iBus_cmd_valid` / `iBus_cmd_ready`  in / out  1  iBus command handshake
- `iBus_cmd_payload_address`  in  ADDR_W  fetch address (always a read)
- `iBus_rsp_valid`  out  1  fetch data valid
- `iBus_rsp_payload_data`  out  DATA_W  fetch data
- `iBus_rsp_payload_error`  out  1  fetch error
- `dBus_cmd_valid` / `dBus_cmd_ready`  in / out  1  dBus command handshake
- `dBus_cmd_payload_wr`  in  1  1 = write
- `dBus_cmd_payload_address`  in  ADDR_W
- `dBus_cmd_payload_data`  in  DATA_W  write data
- `dBus_cmd_payload_mask`  in  DATA_W/8  byte enables
- `dBus_rsp_valid`, `dBus_rsp_payload_data`, `dBus_rsp_payload_error`  out  1/DATA_W/1  read response
- `mem_cmd_valid` / `mem_cmd_ready`  out / in  1  memory command handshake
- `mem_cmd_wr`, `mem_cmd_address`, `mem_cmd_data`, `mem_cmd_mask`  out  1/ADDR_W/DATA_W/DATA_W/8
- `mem_rsp_valid`  in  1; `mem_rsp_data`  in  DATA_W; `mem_rsp_error`  in  1
- `mem_abort`  out  1  one-cycle pulse: memory drops its pending read (timeout build only; tied 0 otherwise)

## Operation
- FSM states: IDLE, CMD, RSP.
- IDLE: if any `*_cmd_valid`, grant one, assert its `*_cmd_ready` for that cycle (combinational), latch its payload into the command register plus `owner` bit, go to CMD. iBus commands are latched with `wr=0`, `mask=all ones`, `data=0`.
- Arbitration: single requester wins. If both request, the master not granted last wins. `last_grant` resets to iBus, so dBus wins the first tie.
- CMD: `mem_cmd_valid=1` with registered payload, held stable until `mem_cmd_ready`. On handshake: write goes to IDLE (no response to dBus); read goes to RSP.
- RSP: `mem_rsp_*` forwarded combinationally to the owner's `*_rsp_*`. The other master's `rsp_valid` stays 0. On `mem_rsp_valid`, go to IDLE.
- `*_cmd_ready` is 0 outside IDLE. One transaction is outstanding at most.
- `mem_rsp_valid` outside RSP is ignored.
- Reset (asynchronous, any state): FSM to IDLE, `last_grant`=iBus, command register 0. All outputs are 0 while reset is low.

## Timing
- Cycle 0: request accepted. Cycle 1: `mem_cmd_valid` high at the earliest.
- Zero-wait-state read: `mem_cmd_ready` in cycle 1, `mem_rsp_valid` in cycle 2, master `rsp_valid` in cycle 2 (same cycle).
- Back-to-back throughput: a new grant is possible in the cycle after returning to IDLE. Best case is 2 cycles per write and 3 per read.
- IDLE grant and payload latch happen in the same edge. A master deasserting valid without ready is allowed.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit+ counter (sized by `$clog2(TIMEOUT+1)`) clears on RSP entry and increments each RSP cycle without `mem_rsp_valid`.
  - When the counter reaches `TIMEOUT`, the owner receives `rsp_valid=1`, `error=1`, `data=0` for one cycle, `mem_abort` pulses, and the FSM goes to IDLE.
  - A response arriving in that same cycle takes precedence: normal forward, no abort.
- Not defined: no counter; RSP waits indefinitely; `mem_abort` is tied to 0.

## Structure
- Shared package `vex_bus_pkg`:
  - State enum (IDLE/CMD/RSP).
  - Owner encoding (`OWNER_IBUS=0`, `OWNER_DBUS=1`).
  - Default widths.
- Sub-module `vex_rr_arb2`: 2-way round-robin grant logic (inputs are the requests and `last_grant`; output is the grant). Everything else is flat.

## Test plan
- iBus read, addr `0x0000_0100`, mem returns `0xDEAD_BEEF` with zero wait → `iBus_cmd_ready` in cycle 0, `mem_cmd_address=0x100` with `wr=0` in cycle 1, `iBus_rsp_data=0xDEAD_BEEF` in cycle 2, `dBus_rsp_valid` stays 0.
- dBus write, addr `0x8000_0004`, data `0x1234_5678`, mask `0x3`, `mem_cmd_ready` delayed 3 cycles → payload stable for the 4 cycles, no `dBus_rsp_valid`, back in IDLE after the handshake.
- Both masters request continuously for 4 grants after reset → grant order dBus, iBus, dBus, iBus.
- dBus read with `mem_rsp_error=1` after 5 cycles → `dBus_rsp_error=1` in the response cycle, iBus still stalled until IDLE.
- `reset` asserted low during CMD and during RSP → all outputs 0 immediately. After release, the first tie goes to dBus.
- With `ARB_TIMEOUT_EN` and `TIMEOUT=16`, memory never responds → error response and `mem_abort` exactly 16 cycles after RSP entry. A response at cycle 16 is forwarded normally with no abort.
